// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a start/ready/done handshake.
// Latency: start accepted at edge k -> first bit in cycle k+1, done one cycle after the last bit.
// Backpressure: start is only honoured while ready=1 (IDLE); start and load_data are ignored mid-frame.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset, discards any frame in progress
//   load_data  WIDTH-bit word, sampled only on the accepting edge
//   start      frame request, accepted when ready=1
//   ready      1 in IDLE
//   busy       1 while frame bits (and parity bit) are being sent
//   serial_out current frame bit, 0 whenever valid=0
//   valid      qualifies serial_out
//   done       one-cycle pulse after the last bit of a frame
//
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             serial_out,
  output logic             valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif
    ready      = 1'b0;
    busy       = 1'b0;
    serial_out = 1'b0;
    valid      = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          sreg_d  = load_data;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^load_data;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        valid      = 1'b1;
        busy       = 1'b1;
        serial_out = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
        sreg_d     = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, sreg_q[WIDTH-1:1]};
        // Counter holds at WIDTH-1 on the final edge instead of wrapping.
        if (cnt_q == LAST_CNT) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        valid      = 1'b1;
        busy       = 1'b1;
        serial_out = par_q;
        state_d    = DONE;
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      // Unused encodings (PARITY when parity is disabled) drive all outputs
      // low and fall back to IDLE on the next edge.
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
